osc_wave_shaper: RTL
====================

Name: osc_wave_shaper

Overview:
- Downstream stage of the oscillator NCO: converts each time-multiplexed 11-bit phase word into a signed 16-bit oscillator sample.
- Per-slot waveform (saw, pulse, triangle, parabolic sine) and pulse width live in a per-voice/per-oscillator config table.
- Runs on the oscillator slot clock. Output feeds the oscillator mixer/level stage with the voice/osc tag kept alongside.

Parameters:
- VOICES, 8, number of voices
- V_OSC, 4, oscillators per voice
- V_WIDTH, 3, voice index width
- O_WIDTH, 2, oscillator index width

Ports:
- sCLK_XVXOSC  in  1  oscillator slot clock; all logic on rising edge
- iRST  in  1  asynchronous active-high reset
- in_valid  in  1  phase_acc/vx/ox valid this cycle
- phase_acc  in  11  phase word from NCO, treated as unsigned
- vx  in  V_WIDTH  voice index aligned with phase_acc
- ox  in  O_WIDTH  oscillator index aligned with phase_acc
- cfg_we  in  1  config table write strobe
- cfg_vx  in  V_WIDTH  config voice index
- cfg_ox  in  O_WIDTH  config osc index
- cfg_wave  in  2  waveform: 0 saw, 1 pulse, 2 triangle, 3 sine
- cfg_pw  in  11  pulse width threshold
- cfg_level  in  8  slot level; used only with OSC_SHAPER_LEVEL_EN
- sample  out  16  signed sample
- out_vx  out  V_WIDTH  voice tag of sample
- out_ox  out  O_WIDTH  osc tag of sample
- out_valid  out  1  sample valid

Behaviour:
- Clocking and reset: one clock, sCLK_XVXOSC. iRST is asynchronous, active-high.
- Reset values: sample=0, out_vx=0, out_ox=0, out_valid=0, all pipeline valids=0. Every table slot resets to wave=0, pw=11'h400, level=8'hFF.
- Reset asserted mid-stream: all in-flight samples are dropped immediately. No valid is emitted until fresh input follows deassertion.
- Config writes:
  - On a cfg_we cycle, the slot [cfg_vx][cfg_ox] is written.
  - Writes with cfg_vx>=VOICES or cfg_ox>=V_OSC are ignored.
- Pipeline: three stages, fixed latency 3. An input valid at edge n produces out_valid at edge n+3. Tags travel with the data.
  - S1: register phase, tags and valid. Read the slot config.
  - S2: compute the waveform.
  - S3: register sample.
- Read/write collision: a write and a read to the same slot in the same cycle → the read sees the old config. The new config applies from the next input.
- Out-of-range input tag (vx>=VOICES or ox>=V_OSC): sample=0, out_valid still asserted.
- When in_valid=0, the output registers still advance with out_valid=0. sample holds its last value.
- Waveform arithmetic (p = phase, 11-bit unsigned; all results saturate-free by construction):
  - Saw: (p − 1024) << 5. p=0 → −32768; p=2047 → 32736.
  - Pulse: p < pw → 32767, else −32768. pw=0 → always −32768.
  - Triangle: t = p[10] ? ~p[9:0] : p[9:0]; out = (t << 6) − 32768. Range −32768..32704.
  - Sine: h = p[9:0]; y = h*(1023−h), 20-bit unsigned; s = y >> 3. out = p[10] ? −s : s. Peak ±32704.

Optional Feature:
- Macro: OSC_SHAPER_LEVEL_EN
- Defined:
  - Adds stage S4: sample = (wave * {1'b0,level}) >>> 8, arithmetic shift.
  - Latency becomes 4; tags and valid are delayed to match.
  - level=0 → 0; level=255 → wave*255/256 truncated toward −inf.
- Undefined: cfg_level is ignored, the level table is not built, and latency is 3.

Test Plan:
- Reset, then in_valid with p=0, slot(0,0) → 3 cycles later out_valid=1, sample=16'h8000 (saw default). Before that, sample=0 and out_valid=0.
- Write slot(2,1) triangle, then stream p=1023, 1024, 2047 → samples 16'h7FC0, 16'h7FC0, 16'h8000 with out_vx=2, out_ox=1.
- Slot pulse with pw=11'h200: p=11'h1FF → 16'h7FFF, p=11'h200 → 16'h8000. Rewrite with pw=0: p=0 → 16'h8000.
- Sine: p=512 → 32704 (16'h7FC0); p=1536 → −32704 (16'h8040); p=0 → 0; p=1024 → 0.
- cfg_we to slot(1,0) with wave=2 in the same cycle as an input for slot(1,0) at p=1023 → saw result 16'hFFE0. The next input at p=1023 → 16'h7FC0. Out-of-range cfg write leaves the table unchanged.
- Assert iRST with 3 valids in flight → out_valid=0 and sample=0 without waiting for a clock edge; the table returns to saw. With OSC_SHAPER_LEVEL_EN and level=128, saw p=0 → −16384 at latency 4.

Source files
------------

// File: rtl/osc_wave_shaper.sv
// Oscillator wave shaper: turns each time-multiplexed NCO phase word into a signed 16-bit sample.
// Define OSC_SHAPER_LEVEL_EN to add a per-slot level multiply stage (latency 4 instead of 3).
module osc_wave_shaper #(
    parameter int unsigned VOICES  = 8,
    parameter int unsigned V_OSC   = 4,
    parameter int unsigned V_WIDTH = 3,
    parameter int unsigned O_WIDTH = 2
) (
    input  logic               sCLK_XVXOSC,
    input  logic               iRST,
    input  logic               in_valid,
    input  logic [10:0]        phase_acc,
    input  logic [V_WIDTH-1:0] vx,
    input  logic [O_WIDTH-1:0] ox,
    input  logic               cfg_we,
    input  logic [V_WIDTH-1:0] cfg_vx,
    input  logic [O_WIDTH-1:0] cfg_ox,
    input  logic [1:0]         cfg_wave,
    input  logic [10:0]        cfg_pw,
    input  logic [7:0]         cfg_level,
    output logic [15:0]        sample,
    output logic [V_WIDTH-1:0] out_vx,
    output logic [O_WIDTH-1:0] out_ox,
    output logic               out_valid
);
    typedef enum logic [1:0] {WaveSaw = 2'd0, WavePulse = 2'd1, WaveTri = 2'd2, WaveSine = 2'd3}
        wave_e;

    wave_e       wave_tbl_q [VOICES][V_OSC];
    logic [10:0] pw_tbl_q   [VOICES][V_OSC];
`ifdef OSC_SHAPER_LEVEL_EN
    logic [7:0]  level_tbl_q [VOICES][V_OSC];
`else
    logic        unused_level;
    assign unused_level = ^cfg_level;
`endif

    logic cfg_in_range, in_range;
    assign cfg_in_range = (32'(cfg_vx) < VOICES) && (32'(cfg_ox) < V_OSC);
    assign in_range     = (32'(vx) < VOICES) && (32'(ox) < V_OSC);

    always_ff @(posedge sCLK_XVXOSC or posedge iRST) begin
        if (iRST) begin
            for (int v = 0; v < int'(VOICES); v++) begin
                for (int o = 0; o < int'(V_OSC); o++) begin
                    wave_tbl_q[v][o] <= WaveSaw;
                    pw_tbl_q[v][o]   <= 11'h400;
`ifdef OSC_SHAPER_LEVEL_EN
                    level_tbl_q[v][o] <= 8'hFF;
`endif
                end
            end
        end else if (cfg_we && cfg_in_range) begin
            wave_tbl_q[cfg_vx][cfg_ox] <= wave_e'(cfg_wave);
            pw_tbl_q[cfg_vx][cfg_ox]   <= cfg_pw;
`ifdef OSC_SHAPER_LEVEL_EN
            level_tbl_q[cfg_vx][cfg_ox] <= cfg_level;
`endif
        end
    end

    // S1: phase, tags and slot config. The table read is registered here, so a same-cycle
    // write to the same slot is only seen by later inputs.
    logic               s1_valid_q, s1_in_range_q;
    logic [10:0]        s1_phase_q, s1_pw_q;
    logic [V_WIDTH-1:0] s1_vx_q;
    logic [O_WIDTH-1:0] s1_ox_q;
    wave_e              s1_wave_q;
`ifdef OSC_SHAPER_LEVEL_EN
    logic [7:0]         s1_level_q;
`endif

    always_ff @(posedge sCLK_XVXOSC or posedge iRST) begin
        if (iRST) begin
            s1_valid_q    <= 1'b0;
            s1_in_range_q <= 1'b0;
            s1_phase_q    <= '0;
            s1_pw_q       <= '0;
            s1_vx_q       <= '0;
            s1_ox_q       <= '0;
            s1_wave_q     <= WaveSaw;
`ifdef OSC_SHAPER_LEVEL_EN
            s1_level_q    <= '0;
`endif
        end else begin
            s1_valid_q    <= in_valid;
            s1_in_range_q <= in_range;
            s1_phase_q    <= phase_acc;
            s1_vx_q       <= vx;
            s1_ox_q       <= ox;
            s1_pw_q       <= in_range ? pw_tbl_q[vx][ox] : 11'd0;
            s1_wave_q     <= in_range ? wave_tbl_q[vx][ox] : WaveSaw;
`ifdef OSC_SHAPER_LEVEL_EN
            s1_level_q    <= in_range ? level_tbl_q[vx][ox] : 8'd0;
`endif
        end
    end

    // S2: waveform arithmetic
    logic [9:0]  tri_t, sine_h;
    logic [19:0] sine_y;
    logic [15:0] sine_s, wave_d;

    always_comb begin
        tri_t  = s1_phase_q[10] ? ~s1_phase_q[9:0] : s1_phase_q[9:0];
        sine_h = s1_phase_q[9:0];
        sine_y = {10'd0, sine_h} * {10'd0, 10'd1023 - sine_h};
        sine_s = 16'(sine_y >> 3);
        wave_d = 16'd0;
        unique case (s1_wave_q)
            WaveSaw:   wave_d = {~s1_phase_q[10], s1_phase_q[9:0], 5'd0};
            WavePulse: wave_d = (s1_phase_q < s1_pw_q) ? 16'h7FFF : 16'h8000;
            WaveTri:   wave_d = {~tri_t[9], tri_t[8:0], 6'd0};
            WaveSine:  wave_d = s1_phase_q[10] ? 16'd0 - sine_s : sine_s;
            default:   wave_d = 16'd0;
        endcase
        if (!s1_in_range_q) begin
            wave_d = 16'd0;
        end
    end

    logic               s2_valid_q;
    logic [15:0]        s2_wave_q;
    logic [V_WIDTH-1:0] s2_vx_q;
    logic [O_WIDTH-1:0] s2_ox_q;
`ifdef OSC_SHAPER_LEVEL_EN
    logic [7:0]         s2_level_q;
`endif

    always_ff @(posedge sCLK_XVXOSC or posedge iRST) begin
        if (iRST) begin
            s2_valid_q <= 1'b0;
            s2_wave_q  <= '0;
            s2_vx_q    <= '0;
            s2_ox_q    <= '0;
`ifdef OSC_SHAPER_LEVEL_EN
            s2_level_q <= '0;
`endif
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_wave_q  <= wave_d;
            s2_vx_q    <= s1_vx_q;
            s2_ox_q    <= s1_ox_q;
`ifdef OSC_SHAPER_LEVEL_EN
            s2_level_q <= s1_level_q;
`endif
        end
    end

    logic               fin_valid;
    logic [15:0]        fin_sample;
    logic [V_WIDTH-1:0] fin_vx;
    logic [O_WIDTH-1:0] fin_ox;

`ifdef OSC_SHAPER_LEVEL_EN
    logic               s3_valid_q;
    logic [15:0]        s3_wave_q;
    logic [7:0]         s3_level_q;
    logic [V_WIDTH-1:0] s3_vx_q;
    logic [O_WIDTH-1:0] s3_ox_q;
    logic signed [24:0] level_prod;

    always_ff @(posedge sCLK_XVXOSC or posedge iRST) begin
        if (iRST) begin
            s3_valid_q <= 1'b0;
            s3_wave_q  <= '0;
            s3_level_q <= '0;
            s3_vx_q    <= '0;
            s3_ox_q    <= '0;
        end else begin
            s3_valid_q <= s2_valid_q;
            s3_wave_q  <= s2_wave_q;
            s3_level_q <= s2_level_q;
            s3_vx_q    <= s2_vx_q;
            s3_ox_q    <= s2_ox_q;
        end
    end

    // Level is unsigned; the zero-extended operand keeps the product signed-correct.
    assign level_prod = $signed(s3_wave_q) * $signed({1'b0, s3_level_q});
    assign fin_valid  = s3_valid_q;
    assign fin_sample = 16'(level_prod >>> 8);
    assign fin_vx     = s3_vx_q;
    assign fin_ox     = s3_ox_q;
`else
    assign fin_valid  = s2_valid_q;
    assign fin_sample = s2_wave_q;
    assign fin_vx     = s2_vx_q;
    assign fin_ox     = s2_ox_q;
`endif

    // Final output stage; sample and tags hold while no valid arrives.
    logic               out_valid_q;
    logic [15:0]        sample_q;
    logic [V_WIDTH-1:0] out_vx_q;
    logic [O_WIDTH-1:0] out_ox_q;

    always_ff @(posedge sCLK_XVXOSC or posedge iRST) begin
        if (iRST) begin
            out_valid_q <= 1'b0;
            sample_q    <= '0;
            out_vx_q    <= '0;
            out_ox_q    <= '0;
        end else begin
            out_valid_q <= fin_valid;
            if (fin_valid) begin
                sample_q <= fin_sample;
                out_vx_q <= fin_vx;
                out_ox_q <= fin_ox;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sample    = sample_q;
    assign out_vx    = out_vx_q;
    assign out_ox    = out_ox_q;

endmodule
